host_cmd_parser: RTL and testbench

Command decoder in the `clk` domain, between the host-link FIFOs.
- Consumes bytes from the read side of the RX FIFO, which is filled by the FT245 interface.
- Decodes fixed-length register read/write packets and drives a simple register bus.
- Pushes one response byte per packet into the write side of the TX FIFO, which drains back to the FT245.
- Replaces the loopback path between the two FIFOs.

---
 rtl/host_cmd_parser_if.sv | 30 +++
 rtl/host_cmd_parser.sv | 152 +++++++++++++++
 tb/tb_host_cmd_parser.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_cmd_parser_if.sv
// Host-link command bus: RX FIFO read side, TX FIFO write side, register bus and status.
interface host_cmd_parser_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [7:0]        rx_rdata;
  logic              rx_rempty;
  logic              rx_rinc;
  logic [7:0]        tx_wdata;
  logic              tx_wfull;
  logic              tx_winc;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              busy;
  logic [7:0]        err_count;

  // Parser side: pops RX, pushes TX, masters the register bus.
  modport master (
    input  rx_rdata, rx_rempty, tx_wfull, reg_rdata,
    output rx_rinc, tx_wdata, tx_winc, reg_addr, reg_wdata, reg_we, reg_re, busy, err_count
  );

  // Environment side: FIFOs, register file and status observers.
  modport slave (
    output rx_rdata, rx_rempty, tx_wfull, reg_rdata,
    input  rx_rinc, tx_wdata, tx_winc, reg_addr, reg_wdata, reg_we, reg_re, busy, err_count
  );
endinterface

// File: rtl/host_cmd_parser.sv
// Host command decoder: parses fixed-length 'W'/'R' packets from the RX FIFO,
// drives a simple register bus and returns one response byte per packet.
module host_cmd_parser #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [7:0]  OP_WR   = 8'h57,
  parameter logic [7:0]  OP_RD   = 8'h52
) (
  input  logic              clk,
  input  logic              rst_n,
  host_cmd_parser_if.master bus
);

  localparam int unsigned     TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [7:0]      RESP_OK  = 8'hAA;
  localparam logic [7:0]      RESP_BAD = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_EXEC_WR,
    S_EXEC_RD,
    S_RD_CAP,
    S_SEND
  } state_t;

  state_t            r_state;
  logic              r_is_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic [7:0]        r_resp;
  logic [TMO_W-1:0]  r_tmo;
  logic [7:0]        r_err;

  state_t            w_state_nxt;
  logic              w_is_wr_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [7:0]        w_data_nxt;
  logic [7:0]        w_resp_nxt;
  logic [TMO_W-1:0]  w_tmo_nxt;
  logic [7:0]        w_err_nxt;
  logic              w_err_inc;
  logic              w_accept;
  logic              w_push;

  // State and datapath registers; reset drops any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_is_wr <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_resp  <= '0;
      r_tmo   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_is_wr <= w_is_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_resp  <= w_resp_nxt;
      r_tmo   <= w_tmo_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, byte accept, inter-byte timeout and error counting.
  always_comb begin
    w_state_nxt = r_state;
    w_is_wr_nxt = r_is_wr;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_resp_nxt  = r_resp;
    w_tmo_nxt   = '0;
    w_err_inc   = 1'b0;
    // Gated by rst_n so the pop stays low while reset is asserted.
    w_accept    = rst_n && !bus.rx_rempty &&
                  (r_state inside {S_IDLE, S_GET_ADDR, S_GET_DATA});
    w_push      = (r_state == S_SEND) && !bus.tx_wfull;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.rx_rdata == OP_WR || bus.rx_rdata == OP_RD) begin
            w_is_wr_nxt = (bus.rx_rdata == OP_WR);
            w_state_nxt = S_GET_ADDR;
          end else begin
            w_resp_nxt  = RESP_BAD;
            w_err_inc   = 1'b1;
            w_state_nxt = S_SEND;
          end
        end
      end
      S_GET_ADDR: begin
        if (w_accept) begin
          w_addr_nxt  = bus.rx_rdata[ADDR_W-1:0];
          w_state_nxt = r_is_wr ? S_GET_DATA : S_EXEC_RD;
        end else if (r_tmo == TMO_LAST) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      S_GET_DATA: begin
        if (w_accept) begin
          w_data_nxt  = bus.rx_rdata;
          w_state_nxt = S_EXEC_WR;
        end else if (r_tmo == TMO_LAST) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      S_EXEC_WR: begin
        w_resp_nxt  = RESP_OK;
        w_state_nxt = S_SEND;
      end
      S_EXEC_RD: begin
        w_state_nxt = S_RD_CAP;
      end
      S_RD_CAP: begin
        w_resp_nxt  = bus.reg_rdata;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_push) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_err_nxt = (w_err_inc && r_err != 8'hFF) ? r_err + 8'd1 : r_err;
  end

  assign bus.rx_rinc   = w_accept;
  assign bus.tx_winc   = w_push;
  assign bus.tx_wdata  = r_resp;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_data;
  assign bus.reg_we    = (r_state == S_EXEC_WR);
  assign bus.reg_re    = (r_state == S_EXEC_RD);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.err_count = r_err;

endmodule

// File: tb/tb_host_cmd_parser.sv
// Randomized bench for host_cmd_parser with a packet-level reference model.
`timescale 1ns/1ps
module tb_host_cmd_parser;
  localparam int unsigned ADDR_W = 6;
  localparam int          TMO    = 16;
  localparam int          GAP    = -1;
  localparam logic [7:0]  OP_WR  = 8'h57;
  localparam logic [7:0]  OP_RD  = 8'h52;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  host_cmd_parser_if #(.ADDR_W(ADDR_W)) bus ();
  host_cmd_parser #(.ADDR_W(ADDR_W), .TIMEOUT(TMO), .OP_WR(OP_WR), .OP_RD(OP_RD))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Power-on contents of the register file (reg 0x12 holds 9D).
  function automatic logic [7:0] init_val(input int i);
    return (i == 18) ? 8'h9D : 8'(i * 7 + 3);
  endfunction

  // Register file: data valid only the cycle after reg_re, noise otherwise.
  logic [7:0] env_mem [64];
  logic [7:0] env_rdata;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= init_val(i);
      env_rdata <= 8'h00;
    end else begin
      if (bus.reg_we) env_mem[bus.reg_addr] <= bus.reg_wdata;
      env_rdata <= bus.reg_re ? env_mem[bus.reg_addr] : 8'($urandom);
    end
  end
  assign bus.reg_rdata = env_rdata;

  int n_tests, n_fail, cyc;
  int rx_q[$];
  bit tok_shown;
  int full_pct, force_full;
  int acc_cyc[$];
  int tx_cyc[$];
  logic [7:0] tx_byte[$];
  int we_cyc[$];
  int we_addr[$];
  logic [7:0] we_data[$];

  // Reference model: partial packet bytes plus scheduled strobe/response times.
  logic [7:0] m_pkt[$];
  logic [7:0] m_mem[64];
  int m_gap, m_stb_cyc, m_resp_cyc, m_addr, m_err;
  bit m_stb_wr;
  logic [7:0] m_wdata, m_resp;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pkt.delete();
    for (int i = 0; i < 64; i++) m_mem[i] = init_val(i);
    m_gap = 0; m_stb_cyc = -1; m_resp_cyc = -1; m_addr = 0; m_err = 0;
    m_stb_wr = 1'b0; m_wdata = 8'h00; m_resp = 8'h00;
  endtask

  task automatic err_bump();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step(input bit acc, input bit push);
    logic [7:0] b;
    if (push) m_resp_cyc = -1;
    if (acc) begin
      b = bus.rx_rdata;
      m_gap = 0;
      if (m_pkt.size() == 0) begin
        if (b == OP_WR || b == OP_RD) m_pkt.push_back(b);
        else begin m_resp = 8'hEE; m_resp_cyc = cyc + 1; err_bump(); end
      end else if (m_pkt.size() == 1) begin
        m_addr = int'(b) % 64;
        if (m_pkt[0] == OP_RD) begin
          m_stb_cyc = cyc + 1; m_stb_wr = 1'b0;
          m_resp = m_mem[m_addr]; m_resp_cyc = cyc + 3;
          m_pkt.delete();
        end else m_pkt.push_back(b);
      end else begin
        m_wdata = b; m_mem[m_addr] = b;
        m_stb_cyc = cyc + 1; m_stb_wr = 1'b1;
        m_resp = 8'hAA; m_resp_cyc = cyc + 2;
        m_pkt.delete();
      end
    end else if (m_pkt.size() > 0) begin
      m_gap++;
      if (m_gap == TMO) begin m_pkt.delete(); m_gap = 0; err_bump(); end
    end
  endtask

  // Per-cycle compare against the model, logging, RX FIFO pops, model advance.
  task automatic model_cycle();
    bit in_send, e_acc, e_winc, e_we, e_re, e_busy;
    if (!rst_n) model_reset();
    in_send = rst_n && m_resp_cyc >= 0 && cyc >= m_resp_cyc;
    e_acc   = rst_n && !bus.rx_rempty && m_resp_cyc < 0;
    e_winc  = in_send && !bus.tx_wfull;
    e_we    = rst_n && cyc == m_stb_cyc && m_stb_wr;
    e_re    = rst_n && cyc == m_stb_cyc && !m_stb_wr;
    e_busy  = rst_n && (m_pkt.size() > 0 || m_resp_cyc >= 0);
    chk("rx_rinc", int'(bus.rx_rinc), int'(e_acc));
    chk("tx_winc", int'(bus.tx_winc), int'(e_winc));
    chk("reg_we", int'(bus.reg_we), int'(e_we));
    chk("reg_re", int'(bus.reg_re), int'(e_re));
    chk("busy", int'(bus.busy), int'(e_busy));
    chk("err_count", int'(bus.err_count), m_err);
    chk("reg_addr", int'(bus.reg_addr), m_addr);
    chk("reg_wdata", int'(bus.reg_wdata), int'(m_wdata));
    if (in_send) chk("tx_wdata", int'(bus.tx_wdata), int'(m_resp));
    if (!rst_n) chk("tx_wdata_rst", int'(bus.tx_wdata), 0);
    if (bus.rx_rinc) acc_cyc.push_back(cyc);
    if (bus.tx_winc) begin tx_cyc.push_back(cyc); tx_byte.push_back(bus.tx_wdata); end
    if (bus.reg_we) begin
      we_cyc.push_back(cyc); we_addr.push_back(int'(bus.reg_addr)); we_data.push_back(bus.reg_wdata);
    end
    if (rx_q.size() > 0)
      if ((rx_q[0] < 0 && tok_shown) || (rx_q[0] >= 0 && bus.rx_rinc)) void'(rx_q.pop_front());
    if (rst_n) model_step(e_acc, e_winc);
    cyc++;
  endtask

  // Input driver: RX head (or an empty-cycle token) and TX full, just after the edge.
  task automatic drive_cycle();
    if (rx_q.size() > 0 && rx_q[0] >= 0) begin
      bus.rx_rempty = 1'b0; bus.rx_rdata = 8'(rx_q[0]); tok_shown = 1'b0;
    end else begin
      bus.rx_rempty = 1'b1; bus.rx_rdata = 8'($urandom); tok_shown = (rx_q.size() > 0);
    end
    if (force_full > 0) begin bus.tx_wfull = 1'b1; force_full--; end
    else bus.tx_wfull = ($urandom_range(0, 99) < full_pct);
  endtask

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic push_b(input logic [7:0] b);
    rx_q.push_back(int'(b));
  endtask

  task automatic push_gap(input int n);
    repeat (n) rx_q.push_back(GAP);
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); tx_cyc.delete(); tx_byte.delete();
    we_cyc.delete(); we_addr.delete(); we_data.delete();
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (n < budget && !(rx_q.size() == 0 && m_pkt.size() == 0 && m_resp_cyc < 0 && !bus.busy)) begin
      tick(); n++;
    end
    chk({nm, "_idle"}, int'(bus.busy) + rx_q.size(), 0);
  endtask

  function automatic int gp(input int g);
    return (g > 0) ? g : $urandom_range(0, 2);
  endfunction

  task automatic push_rand_pkt();
    int kind, g;
    logic [7:0] bad;
    kind = $urandom_range(0, 9);
    g = (kind == 9) ? TMO - 1 : 0;
    push_gap($urandom_range(0, 3));
    case (kind)
      0, 1, 2, 3, 9: begin
        push_b(OP_WR); push_gap(gp(g)); push_b(8'($urandom)); push_gap(gp(g)); push_b(8'($urandom));
      end
      4, 5, 6: begin
        push_b(OP_RD); push_gap(gp(0)); push_b(8'($urandom));
      end
      7: begin
        do bad = 8'($urandom); while (bad == OP_WR || bad == OP_RD);
        push_b(bad);
      end
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          push_b(OP_WR); push_gap(gp(0)); push_b(8'($urandom));
        end else push_b(OP_RD);
        push_gap(TMO);
      end
    endcase
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; tok_shown = 1'b0;
    full_pct = 0; force_full = 0;
    rst_n = 1'b0;
    bus.rx_rempty = 1'b1; bus.rx_rdata = 8'h00; bus.tx_wfull = 1'b0;
    model_reset();
    fork
      forever begin @(posedge clk); #1; drive_cycle(); end
      forever begin @(negedge clk); model_cycle(); end
    join_none

    // Reset state.
    repeat (4) tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.err_count), 0);
    chk("rst_tx_wdata", int'(bus.tx_wdata), 0);
    rst_n = 1'b1;
    tick();

    // Write 57 05 3C back-to-back.
    wait_idle("w0", 20); clear_logs();
    push_b(8'h57); push_b(8'h05); push_b(8'h3C);
    wait_idle("wr", 50);
    chk("wr_we_cnt", we_cyc.size(), 1);
    chk("wr_tx_cnt", tx_cyc.size(), 1);
    if (we_cyc.size() == 1 && tx_cyc.size() == 1 && acc_cyc.size() == 3) begin
      chk("wr_we_lat", we_cyc[0] - acc_cyc[0], 3);
      chk("wr_we_addr", we_addr[0], 5);
      chk("wr_we_data", int'(we_data[0]), 8'h3C);
      chk("wr_tx_lat", tx_cyc[0] - acc_cyc[0], 4);
      chk("wr_tx_byte", int'(tx_byte[0]), 8'hAA);
    end

    // Read 52 12 -> 9D.
    clear_logs();
    push_b(8'h52); push_b(8'h12);
    wait_idle("rd", 50);
    chk("rd_we_cnt", we_cyc.size(), 0);
    chk("rd_tx_cnt", tx_cyc.size(), 1);
    if (tx_cyc.size() == 1) begin
      chk("rd_tx_byte", int'(tx_byte[0]), 8'h9D);
      chk("rd_tx_lat", tx_cyc[0] - acc_cyc[0], 4);
    end

    // Bad opcode then a read of reg 01.
    clear_logs();
    push_b(8'h41); push_b(8'h52); push_b(8'h01);
    wait_idle("bad", 50);
    chk("bad_tx_cnt", tx_cyc.size(), 2);
    if (tx_cyc.size() == 2) begin
      chk("bad_tx0", int'(tx_byte[0]), 8'hEE);
      chk("bad_tx1", int'(tx_byte[1]), 8'h0A);
    end
    chk("bad_err", int'(bus.err_count), 1);

    // Backpressure: TX full for 20 cycles during a write, then a read of the same reg.
    clear_logs();
    force_full = 20;
    push_b(8'h57); push_b(8'h01); push_b(8'h77); push_b(8'h52); push_b(8'h01);
    wait_idle("bp", 100);
    chk("bp_tx_cnt", tx_cyc.size(), 2);
    if (tx_cyc.size() == 2) begin
      chk("bp_tx_lat", tx_cyc[0] - acc_cyc[0], 20);
      chk("bp_tx0", int'(tx_byte[0]), 8'hAA);
      chk("bp_tx1", int'(tx_byte[1]), 8'h77);
    end

    // Timeout after an opcode, then a normal read of reg 00.
    clear_logs();
    push_b(8'h57); push_gap(TMO);
    wait_idle("tmo", 60);
    chk("tmo_err", int'(bus.err_count), 2);
    chk("tmo_tx_cnt", tx_cyc.size(), 0);
    chk("tmo_we_cnt", we_cyc.size(), 0);
    push_b(8'h52); push_b(8'h00);
    wait_idle("tmo_rd", 50);
    chk("tmo_rd_cnt", tx_cyc.size(), 1);
    if (tx_cyc.size() == 1) chk("tmo_rd_byte", int'(tx_byte[0]), 8'h03);

    // Address byte arrives exactly on the expiry cycle.
    clear_logs();
    push_b(8'h57); push_gap(TMO - 1); push_b(8'h09); push_b(8'h5A);
    wait_idle("edge", 80);
    chk("edge_err", int'(bus.err_count), 2);
    chk("edge_we_cnt", we_cyc.size(), 1);
    if (we_cyc.size() == 1 && tx_cyc.size() == 1) begin
      chk("edge_we_lat", we_cyc[0] - acc_cyc[0], TMO + 2);
      chk("edge_we_addr", we_addr[0], 9);
      chk("edge_tx_byte", int'(tx_byte[0]), 8'hAA);
    end

    // Reset while waiting in GET_DATA.
    clear_logs();
    push_b(8'h57); push_b(8'h08); push_gap(6);
    for (int n = 0; n < 20 && m_pkt.size() < 2; n++) tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", int'(bus.busy), 0);
    chk("mrst_err", int'(bus.err_count), 0);
    chk("mrst_addr", int'(bus.reg_addr), 0);
    chk("mrst_we", int'(bus.reg_we), 0);
    chk("mrst_winc", int'(bus.tx_winc), 0);
    chk("mrst_rinc", int'(bus.rx_rinc), 0);
    repeat (3) tick();
    rx_q.delete();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mrst_we_cnt", we_cyc.size(), 0);
    chk("mrst_tx_cnt", tx_cyc.size(), 0);

    // Randomized packet mix with random TX backpressure.
    full_pct = 30;
    for (int p = 0; p < 200; p++) push_rand_pkt();
    wait_idle("rand", 30000);

    // err_count saturation.
    full_pct = 0;
    for (int k = 0; k < 300; k++) push_b(8'h00);
    wait_idle("sat", 3000);
    chk("sat_err", int'(bus.err_count), 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
